// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN ALU pipeline: mode encodings, default sizes
// and the signed saturation helper used by both the accumulator and the requantiser.
package cnn_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_K     = 3;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_SH_W  = 5;

    typedef enum logic [1:0] {
        MODE_CONV      = 2'b00,
        MODE_RELU      = 2'b01,
        MODE_POOL      = 2'b10,
        MODE_CONV_RELU = 2'b11
    } mode_e;

    // Clamp a signed value into the range of a w-bit signed number (w <= 63).
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cnn_sat_round.sv
// Round-half-up arithmetic right shift of the accumulator followed by a clip to
// N signed bits; sat flags any clipping.
module cnn_sat_round
    import cnn_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [SH_W-1:0]  shift,
    output logic signed [N-1:0]     data,
    output logic                    sat
);

    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shifted;
    logic signed [63:0]    wide;
    logic signed [63:0]    clipped;

    // One guard bit keeps acc + half from overflowing; huge shifts collapse to the sign.
    always_comb begin
        acc_x   = {acc[ACC_W-1], acc};
        half    = '0;
        rnd     = acc_x;
        shifted = acc_x;
        if (shift != '0) begin
            if (int'(shift) >= ACC_W) begin
                shifted = acc[ACC_W-1] ? '1 : '0;
            end else begin
                half    = (ACC_W+1)'(1) << (shift - SH_W'(1));
                rnd     = acc_x + half;
                shifted = rnd >>> shift;
            end
        end
        wide    = 64'(shifted);
        clipped = sat_clip(wide, N);
        data    = clipped[N-1:0];
        sat     = (clipped != wide);
    end

endmodule

// File: rtl/cnn_alu_pipe.sv
// Three-stage CNN ALU: multiply window, accumulate channels into a saturating
// accumulator, then requantise / ReLU / max-pool into a registered output.
module cnn_alu_pipe
    import cnn_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K     = DEF_K,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic                in_first,
    input  logic                in_last,
    input  logic [K*K*N-1:0]    pix,
    input  logic [K*K*N-1:0]    wgt,
    input  logic [N-1:0]        bias,
    input  logic [SH_W-1:0]     shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_data,
    output logic                out_sat
);

    localparam int KK = K * K;
    localparam int PW = 2 * N;

    logic en;

    logic signed [PW-1:0] prod_c [KK];
    logic signed [N-1:0]  pix4_c [4];

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    mode_e                s1_mode;
    logic [SH_W-1:0]      s1_shift;
    logic signed [N-1:0]  s1_bias;
    logic signed [N-1:0]  s1_pix [4];
    logic signed [PW-1:0] s1_prod [KK];

    logic signed [ACC_W+1:0] sum_c;
    logic signed [ACC_W+1:0] base_c;
    logic signed [ACC_W+1:0] acc_raw;
    logic signed [63:0]      acc_clip;
    logic                    s1_conv;

    logic signed [ACC_W-1:0] acc;
    logic                    acc_sat;
    logic                    s2_valid;
    mode_e                   s2_mode;
    logic [SH_W-1:0]         s2_shift;
    logic signed [N-1:0]     s2_pix [4];

    logic signed [N-1:0] conv_data;
    logic                conv_sat;
    logic signed [N-1:0] pool_a;
    logic signed [N-1:0] pool_b;
    logic signed [N-1:0] res_data;
    logic                res_sat;

    // A stalled output freezes the whole pipe, so nothing is lost or duplicated.
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    always_comb begin
        for (int i = 0; i < KK; i++) begin
            prod_c[i] = PW'($signed(pix[i*N +: N])) * PW'($signed(wgt[i*N +: N]));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pix4
        if (g < KK) begin : g_real
            assign pix4_c[g] = pix[g*N +: N];
        end else begin : g_pad
            assign pix4_c[g] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_CONV;
            s1_shift <= '0;
            s1_bias  <= '0;
            for (int i = 0; i < 4; i++) s1_pix[i] <= '0;
            for (int i = 0; i < KK; i++) s1_prod[i] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_mode  <= mode_e'(mode);
            s1_shift <= shift;
            s1_bias  <= bias;
            s1_pix   <= pix4_c;
            s1_prod  <= prod_c;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KK; i++) begin
            sum_c = sum_c + (ACC_W+2)'(s1_prod[i]);
        end
        base_c   = s1_first ? (ACC_W+2)'(s1_bias) : (ACC_W+2)'(acc);
        acc_raw  = base_c + sum_c;
        acc_clip = sat_clip(64'(acc_raw), ACC_W);
        s1_conv  = (s1_mode == MODE_CONV) || (s1_mode == MODE_CONV_RELU);
    end

    // RELU/POOL beats bypass the accumulator so they can sit inside a channel loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_sat  <= 1'b0;
            s2_valid <= 1'b0;
            s2_mode  <= MODE_CONV;
            s2_shift <= '0;
            for (int i = 0; i < 4; i++) s2_pix[i] <= '0;
        end else if (en) begin
            s2_valid <= s1_valid & (~s1_conv | s1_last);
            s2_mode  <= s1_mode;
            s2_shift <= s1_shift;
            s2_pix   <= s1_pix;
            if (s1_valid & s1_conv) begin
                acc     <= acc_clip[ACC_W-1:0];
                acc_sat <= (acc_clip != 64'(acc_raw)) | (acc_sat & ~s1_first);
            end
        end
    end

    cnn_sat_round #(
        .N     (N),
        .ACC_W (ACC_W),
        .SH_W  (SH_W)
    ) u_sat_round (
        .acc   (acc),
        .shift (s2_shift),
        .data  (conv_data),
        .sat   (conv_sat)
    );

    always_comb begin
        pool_a   = (s2_pix[0] > s2_pix[1]) ? s2_pix[0] : s2_pix[1];
        pool_b   = (s2_pix[2] > s2_pix[3]) ? s2_pix[2] : s2_pix[3];
        res_data = conv_data;
        res_sat  = conv_sat | acc_sat;
        case (s2_mode)
            MODE_RELU: begin
                res_data = s2_pix[0][N-1] ? '0 : s2_pix[0];
                res_sat  = 1'b0;
            end
            MODE_POOL: begin
                res_data = (pool_a > pool_b) ? pool_a : pool_b;
                res_sat  = 1'b0;
            end
            MODE_CONV_RELU: begin
                if (conv_data[N-1]) res_data = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= res_data;
                out_sat  <= res_sat;
            end
        end
    end

endmodule

// File: tb/tb_cnn_alu_pipe.sv
// Directed bench for cnn_alu_pipe: hand-computed vectors, a stall hold check,
// a random-backpressure stream against a small reference model, and mid-accumulation reset.
module tb_cnn_alu_pipe;
    import cnn_pkg::*;

    localparam int N     = 8;
    localparam int K     = 3;
    localparam int ACC_W = 24;
    localparam int SH_W  = 5;
    localparam int KK    = K * K;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        mode = 2'b00;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [KK*N-1:0]   pix = '0;
    logic [KK*N-1:0]   wgt = '0;
    logic [N-1:0]      bias = '0;
    logic [SH_W-1:0]   shift = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N-1:0]      out_data;
    logic              out_sat;

    int checks = 0;
    int failures = 0;
    bit rand_bp = 1'b0;

    typedef struct { int data; int sat; } res_t;
    res_t obs_q[$];
    res_t exp_q[$];

    cnn_alu_pipe #(.N(N), .K(K), .ACC_W(ACC_W), .SH_W(SH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_first  (in_first),
        .in_last   (in_last),
        .pix       (pix),
        .wgt       (wgt),
        .bias      (bias),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge view matches what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            obs_q.push_back('{int'($signed(out_data)), int'(out_sat)});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [KK*N-1:0] fillAll(input int v);
        logic [KK*N-1:0] r;
        for (int i = 0; i < KK; i++) r[i*N +: N] = N'(v);
        return r;
    endfunction

    function automatic logic [KK*N-1:0] setElem(input logic [KK*N-1:0] vec, input int idx, input int v);
        vec[idx*N +: N] = N'(v);
        return vec;
    endfunction

    function automatic void refConv(input logic [KK*N-1:0] p, input logic [KK*N-1:0] w,
                                    input int b, input int sh, input bit relu,
                                    output int d, output int s);
        longint a;
        longint c;
        longint total;
        longint r;
        total = b;
        for (int i = 0; i < KK; i++) begin
            a = $signed(p[i*N +: N]);
            c = $signed(w[i*N +: N]);
            total += a * c;
        end
        if (sh == 0)          r = total;
        else if (sh >= ACC_W) r = (total < 0) ? -1 : 0;
        else                  r = (total + (longint'(1) << (sh - 1))) >>> sh;
        s = (r > 127 || r < -128) ? 1 : 0;
        d = (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
        if (relu && d < 0) d = 0;
    endfunction

    // Present one beat and hold it until accepted; returns at posedge+1 of the accepting edge.
    task automatic applyStimulus(input logic [1:0] m, input logic f, input logic l,
                                 input int b, input int s,
                                 input logic [KK*N-1:0] p, input logic [KK*N-1:0] w);
        bit taken = 1'b0;
        mode = m; in_first = f; in_last = l;
        bias = N'(b); shift = SH_W'(s); pix = p; wgt = w;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            if (taken) break;
        end
        in_valid = 1'b0;
        if (!taken) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitResult(output int d, output int s);
        d = -999; s = -999;
        for (int c = 0; c < 100; c++) begin
            if (obs_q.size() > 0) break;
            @(posedge clk);
            #1;
        end
        if (obs_q.size() == 0) begin
            checkOutput("result_timeout", 0, 1);
        end else begin
            d = obs_q[0].data;
            s = obs_q[0].sat;
            void'(obs_q.pop_front());
        end
    endtask

    task automatic sendAndCheck(input string tag, input logic [1:0] m, input logic f, input logic l,
                                input int b, input int s, input logic [KK*N-1:0] p,
                                input logic [KK*N-1:0] w, input int exp_d, input int exp_s);
        int d;
        int st;
        applyStimulus(m, f, l, b, s, p, w);
        waitResult(d, st);
        checkOutput({tag, "_data"}, d, exp_d);
        checkOutput({tag, "_sat"}, st, exp_s);
    endtask

    initial begin
        logic [KK*N-1:0] p;
        logic [KK*N-1:0] w;
        logic [KK*N-1:0] w10;
        int d;
        int st;
        logic [1:0] m;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_data", int'(out_data), 0);
        checkOutput("rst_sat", int'(out_sat), 0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);

        // Single-channel conv with the latency walked edge by edge: 9*1*2 + 3 = 21.
        applyStimulus(MODE_CONV, 1'b1, 1'b1, 3, 0, fillAll(1), fillAll(2));
        checkOutput("lat_e0", int'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("lat_e1", int'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("lat_e2", int'(out_valid), 1);
        waitResult(d, st);
        checkOutput("conv21_data", d, 21);
        checkOutput("conv21_sat", st, 0);

        sendAndCheck("conv_sh2", MODE_CONV, 1'b1, 1'b1, 3, 2, fillAll(1), fillAll(2), 5, 0);
        sendAndCheck("conv_pos_clip", MODE_CONV, 1'b1, 1'b1, 0, 0, fillAll(127), fillAll(127), 127, 1);
        sendAndCheck("conv_neg_clip", MODE_CONV, 1'b1, 1'b1, 0, 0, fillAll(127), fillAll(-127), -128, 1);

        // Three-channel accumulation (10 each) with a ReLU beat slipped inside it.
        w10 = setElem(fillAll(1), 0, 2);
        applyStimulus(MODE_CONV, 1'b1, 1'b0, 0, 0, fillAll(1), w10);
        applyStimulus(MODE_RELU, 1'b0, 1'b0, 0, 0, setElem(fillAll(0), 0, -5), fillAll(0));
        applyStimulus(MODE_CONV, 1'b0, 1'b0, 0, 0, fillAll(1), w10);
        applyStimulus(MODE_CONV, 1'b0, 1'b1, 0, 0, fillAll(1), w10);
        waitResult(d, st);
        checkOutput("inter_relu_data", d, 0);
        checkOutput("inter_relu_sat", st, 0);
        waitResult(d, st);
        checkOutput("inter_conv_data", d, 30);
        checkOutput("inter_conv_sat", st, 0);
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("inter_no_extra", obs_q.size(), 0);

        p = fillAll(0);
        p = setElem(p, 0, -3); p = setElem(p, 1, 9); p = setElem(p, 2, 4); p = setElem(p, 3, -128);
        sendAndCheck("pool", MODE_POOL, 1'b0, 1'b0, 0, 0, p, fillAll(0), 9, 0);
        sendAndCheck("relu_pos", MODE_RELU, 1'b0, 1'b0, 0, 0, setElem(fillAll(0), 0, 7), fillAll(0), 7, 0);

        // Window sum -40: ReLU clamps it, big shifts collapse to sign, shift 3 rounds to -5.
        p = setElem(fillAll(0), 0, -8);
        w = setElem(fillAll(0), 0, 5);
        sendAndCheck("conv_relu_neg", MODE_CONV_RELU, 1'b1, 1'b1, 0, 0, p, w, 0, 0);
        sendAndCheck("conv_neg_sh3", MODE_CONV, 1'b1, 1'b1, 0, 3, p, w, -5, 0);
        sendAndCheck("conv_neg_sh31", MODE_CONV, 1'b1, 1'b1, 0, 31, p, w, -1, 0);
        sendAndCheck("conv_pos_sh30", MODE_CONV, 1'b1, 1'b1, 3, 30, fillAll(1), fillAll(2), 0, 0);

        // Hold the output for five cycles.
        out_ready = 1'b0;
        applyStimulus(MODE_CONV, 1'b1, 1'b1, 3, 0, fillAll(1), fillAll(2));
        for (int c = 0; c < 20; c++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        checkOutput("stall_valid", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_data", int'($signed(out_data)), 21);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitResult(d, st);
        checkOutput("stall_release_data", d, 21);

        // Streaming with random backpressure.
        rand_bp = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int bb;
            int sh;
            int ed;
            int es;
            for (int i = 0; i < KK; i++) begin
                p[i*N +: N] = N'($urandom);
                w[i*N +: N] = N'($urandom);
            end
            bb = $signed(N'($urandom));
            sh = $urandom_range(0, 9);
            m  = ($urandom_range(0, 1) == 1) ? MODE_CONV_RELU : MODE_CONV;
            refConv(p, w, bb, sh, (m == MODE_CONV_RELU), ed, es);
            exp_q.push_back('{ed, es});
            applyStimulus(m, 1'b1, 1'b1, bb, sh, p, w);
        end
        for (int c = 0; c < 500; c++) begin
            if (obs_q.size() >= 8) break;
            @(posedge clk); #1;
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("stream_count", obs_q.size(), 8);
        for (int b = 0; b < 8; b++) begin
            if (obs_q.size() == 0) break;
            checkOutput($sformatf("stream%0d_data", b), obs_q[0].data, exp_q[b].data);
            checkOutput($sformatf("stream%0d_sat", b), obs_q[0].sat, exp_q[b].sat);
            void'(obs_q.pop_front());
        end

        // Reset in the middle of an accumulation, with a nonzero result still held.
        sendAndCheck("pre_rst", MODE_CONV, 1'b1, 1'b1, 3, 0, fillAll(1), fillAll(2), 21, 0);
        applyStimulus(MODE_CONV, 1'b1, 1'b0, 3, 0, fillAll(1), fillAll(2));
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(out_valid), 0);
        checkOutput("mid_rst_data", int'(out_data), 0);
        checkOutput("mid_rst_sat", int'(out_sat), 0);
        @(negedge clk) rst_n = 1'b1;
        obs_q.delete();
        @(posedge clk); #1;
        checkOutput("mid_rst_in_ready", int'(in_ready), 1);
        sendAndCheck("after_rst_cont", MODE_CONV, 1'b0, 1'b1, 0, 0, fillAll(1), w10, 10, 0);
        sendAndCheck("after_rst_single", MODE_CONV, 1'b1, 1'b1, 3, 0, fillAll(1), fillAll(2), 21, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/cnn_alu_pipe.md
Name: cnn_alu_pipe

Overview:
- Pipelined, parametrised successor to the combinational CNN co-processor ALU.
- Performs a K×K convolution MAC with bias, rounding, saturation and optional ReLU.
- Also performs standalone ReLU and 2×2 max-pool.
- Adds multi-channel partial-sum accumulation and valid/ready backpressure.
- Sits between the image/filter window buffers and the output feature-map writer.

Parameters:
- N, 8, data width of pixels, weights, bias and result (signed two's complement).
- K, 3, kernel side length, legal range 1..5; window holds K*K elements.
- ACC_W, 24, accumulator width (signed); must be ≥ 2*N + clog2(K*K) + 1.
- SH_W, 5, width of the runtime shift amount.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- mode  in  2  00 CONV, 01 RELU, 10 POOL, 11 CONV_RELU.
- in_first  in  1  CONV modes: beat starts a new accumulation (acc := bias + sum).
- in_last  in  1  CONV modes: beat ends the accumulation and produces output.
- pix  in  K*K*N  window, element i at pix[i*N +: N].
- wgt  in  K*K*N  weights, element i at wgt[i*N +: N].
- bias  in  N  signed bias, used only on in_first beats.
- shift  in  SH_W  right-shift amount, used only on in_last beats.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  N  signed result.
- out_sat  out  1  result was clipped by saturation (valid with out_data).

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_sat=0, accumulator=0, all stage valids=0; in_ready=1 after release. Reset mid-accumulation discards the partial sum.
- Pipeline: 3 stages with a global enable en = ~(out_valid & ~out_ready); in_ready = en. Stalls freeze all stages; out_data/out_sat are held stable while out_valid & ~out_ready.
- Latency: an accepted beat that produces output appears 3 enabled cycles later. Bubbles are not collapsed.
- S1: register K*K signed products (2N bits each) plus the tags mode, first, last, shift, bias, pix[0..3].
- S2, CONV modes: tree-sum the products.
  - first=1: acc := sext(bias) + sum.
  - otherwise: acc := acc + sum.
  - The accumulator saturates at the ACC_W signed limits and records a sticky acc_sat; acc_sat is cleared on a first beat.
  - A beat with last=0 produces no output.
- S2, RELU/POOL beats: pass through and never modify acc or acc_sat, so they may be interleaved inside an accumulation.
- S3 CONV:
  - r = shift>0 ? (acc + (1<<(shift-1))) >>> shift : acc (arithmetic shift, round half up).
  - Clip r to [-2^(N-1), 2^(N-1)-1].
  - out_sat = clipped | acc_sat.
  - CONV_RELU additionally forces negative results to 0.
- S3 RELU: out_data = pix[0] < 0 ? 0 : pix[0]; out_sat = 0.
- S3 POOL: out_data = signed max(pix[0], pix[1], pix[2], pix[3]); out_sat = 0. Requires K ≥ 2.
- in_first & in_last on the same beat is a single-channel conv.
- in_last without a preceding in_first continues the existing acc.
- A CONV beat with first=0 after reset accumulates onto 0.
- shift ≥ ACC_W yields 0 for positive and -1 for negative acc before rounding; no X.

Decomposition:
- Shared package cnn_pkg: mode encodings (MODE_CONV, MODE_RELU, MODE_POOL, MODE_CONV_RELU), default N/K/ACC_W, and sat_clip function.
- One sub-module: cnn_sat_round (rounding shift + clip + sat flag), reused later by the requantiser.

Test Plan:
- CONV, first=last=1, all pix=1, wgt=2, bias=3, shift=0 → out_data=21, out_sat=0, 3 cycles after acceptance.
- Same beat with shift=2 → (21+2)>>>2 = 5. With all pix=127, wgt=127, bias=0 → 127, out_sat=1. With wgt=-127 → -128, out_sat=1.
- Three CONV beats (first, mid, last), each window sum 10, bias=0, with a RELU beat pix[0]=-5 interleaved → exactly two outputs, in order: RELU 0, then CONV 30.
- POOL with pix[0..3] = -3, 9, 4, -128 → 9. RELU with pix[0]=7 → 7. CONV_RELU with sum -40 → 0.
- Hold out_ready=0 for 5 cycles with out_valid=1 → in_ready=0, out_data stable. Streaming 8 beats with random backpressure matches the reference model with no loss or duplication.
- Assert rst_n low between first and last beats → outputs zero immediately. A subsequent first=last=1 beat gives the correct stand-alone result.
